// File: rtl/scr_smi_master.sv
// -----------------------------------------------------------------------------
// scr_smi_master
//
// Turns one burst command (read or write, start address, beat count) into a
// sequence of single-beat SMI requests. Only one SMI request is outstanding
// at a time. Read data is returned one rsp beat per SMI response, in address
// order. A write returns one rsp beat carrying the last SMI response.
//
// Ports
//   clk, reset               sole clock; asynchronous active-high reset
//   io_cmd_*                 command channel (valid/ready), accepted in IDLE only
//   io_rsp_*                 response channel to the command issuer
//   io_smi_req_*             SMI request channel (one beat per request)
//   io_smi_resp_*            SMI response channel, accepted in WAIT only
//
// Optional feature
//   SCR_SMI_MASTER_TIMEOUT_EN  When defined, a WAIT that sees no response for
//                              TIMEOUT_CYCLES cycles ends the command with a
//                              single rsp beat flagged err=1, data=0, last=1.
//                              When undefined, WAIT waits forever and
//                              io_rsp_bits_err is tied to 0.
// -----------------------------------------------------------------------------
module scr_smi_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,

    output logic        io_cmd_ready,
    input  logic        io_cmd_valid,
    input  logic        io_cmd_bits_rw,
    input  logic [5:0]  io_cmd_bits_addr,
    input  logic [63:0] io_cmd_bits_data,
    input  logic [5:0]  io_cmd_bits_len,

    input  logic        io_rsp_ready,
    output logic        io_rsp_valid,
    output logic [63:0] io_rsp_bits_data,
    output logic        io_rsp_bits_last,
    output logic        io_rsp_bits_err,

    input  logic        io_smi_req_ready,
    output logic        io_smi_req_valid,
    output logic        io_smi_req_bits_rw,
    output logic [5:0]  io_smi_req_bits_addr,
    output logic [63:0] io_smi_req_bits_data,

    output logic        io_smi_resp_ready,
    input  logic        io_smi_resp_valid,
    input  logic [63:0] io_smi_resp_bits
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RSP
    } state_t;

    state_t      state_q, state_d;
    logic        rw_q, rw_d;
    logic [5:0]  addr_q, addr_d;
    logic [5:0]  len_q, len_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] data_q, data_d;
    logic [63:0] rsp_data_q, rsp_data_d;
    logic        last_beat;

    assign last_beat = (cnt_q == len_q);

`ifdef SCR_SMI_MASTER_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_q, tmo_d;
    logic       err_q, err_d;

    // A timed-out beat always ends the command, whatever the beat count says.
    assign io_rsp_bits_err  = err_q;
    assign io_rsp_bits_last = last_beat | err_q;
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;

    assign io_rsp_bits_err  = 1'b0;
    assign io_rsp_bits_last = last_beat;
`endif

    assign io_rsp_bits_data     = rsp_data_q;
    assign io_smi_req_bits_rw   = rw_q;
    assign io_smi_req_bits_addr = addr_q;
    assign io_smi_req_bits_data = data_q;

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
`ifdef SCR_SMI_MASTER_TIMEOUT_EN
        tmo_d      = tmo_q;
        err_d      = err_q;
`endif

        io_cmd_ready      = (state_q == IDLE);
        io_smi_req_valid  = (state_q == REQ);
        io_smi_resp_ready = (state_q == WAIT);
        io_rsp_valid      = (state_q == RSP);

        case (state_q)
            IDLE: begin
                if (io_cmd_valid) begin
                    rw_d    = io_cmd_bits_rw;
                    addr_d  = io_cmd_bits_addr;
                    data_d  = io_cmd_bits_data;
                    len_d   = io_cmd_bits_len;
                    cnt_d   = 6'd0;
                    state_d = REQ;
                end
            end

            REQ: begin
                if (io_smi_req_ready) begin
                    state_d = WAIT;
`ifdef SCR_SMI_MASTER_TIMEOUT_EN
                    tmo_d   = 8'd0;
`endif
                end
            end

            WAIT: begin
                if (io_smi_resp_valid) begin
                    rsp_data_d = io_smi_resp_bits;
                    // Intermediate write beats produce no rsp beat: issue
                    // the next request directly.
                    if (!rw_q || last_beat) begin
                        state_d = RSP;
                    end else begin
                        addr_d  = addr_q + 6'd1;
                        cnt_d   = cnt_q + 6'd1;
                        state_d = REQ;
                    end
                end
`ifdef SCR_SMI_MASTER_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    rsp_data_d = 64'd0;
                    err_d      = 1'b1;
                    state_d    = RSP;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
`endif
            end

            RSP: begin
                if (io_rsp_ready) begin
`ifdef SCR_SMI_MASTER_TIMEOUT_EN
                    err_d = 1'b0;
`endif
                    if (io_rsp_bits_last) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + 6'd1;
                        cnt_d   = cnt_q + 6'd1;
                        state_d = REQ;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values computed above, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the datapath registers are reset as well, because their
            // values drive outputs whose reset state is observable.
            state_q    <= IDLE;
            rw_q       <= 1'b0;
            addr_q     <= 6'd0;
            len_q      <= 6'd0;
            cnt_q      <= 6'd0;
            data_q     <= 64'd0;
            rsp_data_q <= 64'd0;
`ifdef SCR_SMI_MASTER_TIMEOUT_EN
            tmo_q      <= 8'd0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            rsp_data_q <= rsp_data_d;
`ifdef SCR_SMI_MASTER_TIMEOUT_EN
            tmo_q      <= tmo_d;
            err_q      <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_scr_smi_master.sv
// -----------------------------------------------------------------------------
// tb_scr_smi_master
//
// Self-checking bench for scr_smi_master. A bench-side SMI responder and rsp
// consumer run with random ready/latency; every command is compared against
// an expected transaction list computed from the burst rules (address
// sequence, beat counts, data routing). Directed cases cover the
// backpressure, stall, mid-burst reset and WAIT timeout behaviour.
// -----------------------------------------------------------------------------
module tb_scr_smi_master;

    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        io_cmd_ready;
    logic        io_cmd_valid = 1'b0;
    logic        io_cmd_bits_rw = 1'b0;
    logic [5:0]  io_cmd_bits_addr = 6'd0;
    logic [63:0] io_cmd_bits_data = 64'd0;
    logic [5:0]  io_cmd_bits_len = 6'd0;
    logic        io_rsp_ready = 1'b0;
    logic        io_rsp_valid;
    logic [63:0] io_rsp_bits_data;
    logic        io_rsp_bits_last;
    logic        io_rsp_bits_err;
    logic        io_smi_req_ready = 1'b0;
    logic        io_smi_req_valid;
    logic        io_smi_req_bits_rw;
    logic [5:0]  io_smi_req_bits_addr;
    logic [63:0] io_smi_req_bits_data;
    logic        io_smi_resp_ready;
    logic        io_smi_resp_valid = 1'b0;
    logic [63:0] io_smi_resp_bits = 64'd0;

    scr_smi_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk                  (clk),
        .reset                (reset),
        .io_cmd_ready         (io_cmd_ready),
        .io_cmd_valid         (io_cmd_valid),
        .io_cmd_bits_rw       (io_cmd_bits_rw),
        .io_cmd_bits_addr     (io_cmd_bits_addr),
        .io_cmd_bits_data     (io_cmd_bits_data),
        .io_cmd_bits_len      (io_cmd_bits_len),
        .io_rsp_ready         (io_rsp_ready),
        .io_rsp_valid         (io_rsp_valid),
        .io_rsp_bits_data     (io_rsp_bits_data),
        .io_rsp_bits_last     (io_rsp_bits_last),
        .io_rsp_bits_err      (io_rsp_bits_err),
        .io_smi_req_ready     (io_smi_req_ready),
        .io_smi_req_valid     (io_smi_req_valid),
        .io_smi_req_bits_rw   (io_smi_req_bits_rw),
        .io_smi_req_bits_addr (io_smi_req_bits_addr),
        .io_smi_req_bits_data (io_smi_req_bits_data),
        .io_smi_resp_ready    (io_smi_resp_ready),
        .io_smi_resp_valid    (io_smi_resp_valid),
        .io_smi_resp_bits     (io_smi_resp_bits)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw;
        logic [5:0]  addr;
        logic [63:0] data;
    } req_t;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic        err;
    } beat_t;

    req_t        req_q[$];
    beat_t       beat_q[$];
    logic [63:0] resp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // responder / consumer controls
    bit          pending = 1'b0;
    int          resp_delay = 0;
    int          silent_idx = 1000;   // requests with this index or above get no response
    bit          fixed_en = 1'b0;
    logic [63:0] fixed_val = 64'd0;
    int          hold_beat = -1;
    int          hold_left = 0;
    bit          hold_started = 1'b0;
    beat_t       hold_snap;
    int          stall_left = 0;
    bit          stall_started = 1'b0;
    req_t        stall_snap;
    int          wait_cycles = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic finish_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    task automatic clear_bench();
        req_q.delete();
        beat_q.delete();
        resp_q.delete();
        pending = 1'b0;
    endtask

    // One clock of the bench-side responder and consumer. Inputs are set at
    // the falling edge; a handshake seen here fires on the next rising edge.
    task automatic step();
        req_t        r;
        beat_t       b;
        logic [63:0] v;
        @(negedge clk);
        if (io_smi_resp_ready) wait_cycles++;

        io_smi_resp_valid = 1'b0;
        if (pending && io_smi_resp_ready && (req_q.size() - 1) < silent_idx) begin
            if (resp_delay > 0) begin
                resp_delay--;
            end else begin
                v = fixed_en ? fixed_val : {$urandom, $urandom};
                io_smi_resp_valid = 1'b1;
                io_smi_resp_bits  = v;
                resp_q.push_back(v);
                pending = 1'b0;
            end
        end

        r.rw   = io_smi_req_bits_rw;
        r.addr = io_smi_req_bits_addr;
        r.data = io_smi_req_bits_data;
        io_smi_req_ready = ($urandom_range(0, 3) != 0);
        if (stall_left > 0 && (stall_started || io_smi_req_valid)) begin
            io_smi_req_ready = 1'b0;
            check("stall_req_valid", io_smi_req_valid, 1);
            check("stall_cmd_ready", io_cmd_ready, 0);
            if (stall_started) begin
                check("stall_rw",   r.rw,   stall_snap.rw);
                check("stall_addr", r.addr, stall_snap.addr);
                check("stall_data", r.data, stall_snap.data);
            end
            stall_snap    = r;
            stall_started = 1'b1;
            stall_left--;
            if (stall_left == 0) stall_started = 1'b0;
        end
        if (io_smi_req_valid && io_smi_req_ready) begin
            check("one_outstanding", pending, 0);
            req_q.push_back(r);
            pending    = 1'b1;
            resp_delay = $urandom_range(0, 3);
        end

        b.data = io_rsp_bits_data;
        b.last = io_rsp_bits_last;
        b.err  = io_rsp_bits_err;
        if (hold_left > 0 && (hold_started || (io_rsp_valid && beat_q.size() == hold_beat))) begin
            io_rsp_ready = 1'b0;
            check("hold_rsp_valid", io_rsp_valid, 1);
            check("hold_no_req", io_smi_req_valid, 0);
            if (hold_started) begin
                check("hold_data", b.data, hold_snap.data);
                check("hold_last", b.last, hold_snap.last);
                check("hold_err",  b.err,  hold_snap.err);
            end
            hold_snap    = b;
            hold_started = 1'b1;
            hold_left--;
            if (hold_left == 0) hold_started = 1'b0;
        end else begin
            io_rsp_ready = ($urandom_range(0, 3) != 0);
        end
        if (io_rsp_valid && io_rsp_ready) beat_q.push_back(b);
    endtask

    // Called at a falling edge; returns one falling edge after acceptance.
    task automatic send_cmd(input logic rw, input logic [5:0] a, input logic [63:0] d,
                            input logic [5:0] l);
        int budget = 500;
        while (!io_cmd_ready && budget > 0) begin
            step();
            budget--;
        end
        check("cmd_ready_seen", io_cmd_ready, 1);
        io_cmd_valid     = 1'b1;
        io_cmd_bits_rw   = rw;
        io_cmd_bits_addr = a;
        io_cmd_bits_data = d;
        io_cmd_bits_len  = l;
        step();
        io_cmd_valid     = 1'b0;
        // scramble the idle command fields to prove they were captured
        io_cmd_bits_rw   = 1'($urandom);
        io_cmd_bits_addr = 6'($urandom);
        io_cmd_bits_data = {$urandom, $urandom};
        io_cmd_bits_len  = 6'($urandom);
    endtask

    task automatic wait_beats(input int n, input int budget);
        while (beat_q.size() < n && budget > 0) begin
            step();
            budget--;
        end
    endtask

    // Full command against the reference model: len+1 requests at
    // (addr+i) mod 64; a read returns each response in order, a write
    // returns only the last response.
    task automatic run_cmd(input logic rw, input logic [5:0] a, input logic [63:0] d,
                           input logic [5:0] l);
        int n_req;
        int n_beat;
        clear_bench();
        n_req  = int'(l) + 1;
        n_beat = rw ? 1 : n_req;
        send_cmd(rw, a, d, l);
        wait_beats(n_beat, 6000);
        step();
        check("n_req",  req_q.size(),  n_req);
        check("n_beat", beat_q.size(), n_beat);
        for (int i = 0; i < n_req && i < req_q.size(); i++) begin
            check("req_rw",   req_q[i].rw,   rw);
            check("req_addr", req_q[i].addr, (int'(a) + i) % 64);
            check("req_data", req_q[i].data, d);
        end
        for (int i = 0; i < n_beat && i < beat_q.size(); i++) begin
            if (resp_q.size() > (rw ? n_req - 1 : i))
                check("rsp_data", beat_q[i].data, rw ? resp_q[n_req - 1] : resp_q[i]);
            check("rsp_last", beat_q[i].last, (i == n_beat - 1));
            check("rsp_err",  beat_q[i].err,  0);
        end
        check("back_to_idle", io_cmd_ready, 1);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [5:0] l;
        int budget;

        // reset state, both while reset is held and right after release
        repeat (3) @(negedge clk);
        check("rst_req_valid",  io_smi_req_valid,  0);
        check("rst_resp_ready", io_smi_resp_ready, 0);
        check("rst_rsp_valid",  io_rsp_valid,      0);
        check("rst_err",        io_rsp_bits_err,   0);
        check("rst_rsp_data",   io_rsp_bits_data,  0);
        check("rst_req_addr",   io_smi_req_bits_addr, 0);
        check("rst_cmd_ready",  io_cmd_ready,      1);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", io_cmd_ready, 1);

        // single-beat read returning 0xDEAD
        fixed_en  = 1'b1;
        fixed_val = 64'hDEAD;
        run_cmd(1'b0, 6'd5, {$urandom, $urandom}, 6'd0);
        fixed_en  = 1'b0;

        // write burst wrapping the address from 63 to 0
        run_cmd(1'b1, 6'd62, 64'hA5, 6'd3);

        // rsp consumer stalls beat 1 of a 3-beat read for 4 cycles
        hold_beat = 1;
        hold_left = 4;
        run_cmd(1'b0, 6'($urandom), {$urandom, $urandom}, 6'd2);
        check("hold_consumed", hold_left, 0);

        // SMI responder stalls the first request for 10 cycles
        stall_left = 10;
        run_cmd(1'b1, 6'($urandom), {$urandom, $urandom}, 6'd1);
        check("stall_consumed", stall_left, 0);

        // reset in the WAIT of beat 2 of 4, no clock edge before the check
        clear_bench();
        silent_idx = 1;
        send_cmd(1'b0, 6'd20, {$urandom, $urandom}, 6'd3);
        budget = 500;
        while (!(req_q.size() == 2 && io_smi_resp_ready) && budget > 0) begin
            step();
            budget--;
        end
        check("midburst_in_wait", io_smi_resp_ready, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_req_valid",  io_smi_req_valid,  0);
        check("arst_resp_ready", io_smi_resp_ready, 0);
        check("arst_rsp_valid",  io_rsp_valid,      0);
        check("arst_cmd_ready",  io_cmd_ready,      1);
        @(negedge clk);
        reset = 1'b0;
        io_smi_resp_valid = 1'b1;     // stale response must be ignored
        io_smi_resp_bits  = {$urandom, $urandom};
        @(negedge clk);
        io_smi_resp_valid = 1'b0;
        check("stale_rsp_valid", io_rsp_valid,     0);
        check("stale_req_valid", io_smi_req_valid, 0);
        check("stale_cmd_ready", io_cmd_ready,     1);
        silent_idx = 1000;
        run_cmd(1'b0, 6'd40, {$urandom, $urandom}, 6'd3);

        // silent responder
        clear_bench();
        silent_idx = 0;
        wait_cycles = 0;
`ifdef SCR_SMI_MASTER_TIMEOUT_EN
        send_cmd(1'b0, 6'($urandom), {$urandom, $urandom}, 6'd2);
        wait_beats(1, 2000);
        step();
        check("tmo_beats", beat_q.size(), 1);
        if (beat_q.size() > 0) begin
            check("tmo_err",  beat_q[0].err,  1);
            check("tmo_last", beat_q[0].last, 1);
            check("tmo_data", beat_q[0].data, 0);
        end
        check("tmo_wait_cycles", wait_cycles, TMO);
        check("tmo_reqs", req_q.size(), 1);
        check("tmo_idle", io_cmd_ready, 1);
`else
        send_cmd(1'b0, 6'($urandom), {$urandom, $urandom}, 6'd2);
        repeat (300) step();
        check("nowait_beats", beat_q.size(), 0);
        check("nowait_in_wait", io_smi_resp_ready, 1);
        check("nowait_err", io_rsp_bits_err, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("nowait_reset_idle", io_cmd_ready, 1);
`endif
        silent_idx = 1000;
        clear_bench();

        // randomized commands, mostly short bursts with some long ones
        for (int k = 0; k < 30; k++) begin
            l = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                             : 6'($urandom_range(0, 7));
            run_cmd(1'($urandom), 6'($urandom), {$urandom, $urandom}, l);
        end

        finish_run();
    end

endmodule
